// File: rtl/vga_timing_pkg.sv
// Shared timing types, resolution presets and colour-bar constants for the
// DE10-Nano video timing generator.
package vga_timing_pkg;

    typedef struct packed {
        int disp;
        int fp;
        int pulse;
        int bp;
    } timing_t;

    typedef struct packed {
        timing_t h;
        timing_t v;
    } video_mode_t;

    localparam video_mode_t TIMING_800x480 = '{
        h: '{disp: 800, fp: 40, pulse: 48, bp: 40},
        v: '{disp: 480, fp: 13, pulse: 3,  bp: 29}
    };

    localparam video_mode_t TIMING_640x480 = '{
        h: '{disp: 640, fp: 16, pulse: 96, bp: 48},
        v: '{disp: 480, fp: 10, pulse: 2,  bp: 33}
    };

    localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
    localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
    localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] RGB_RED     = 24'hFF0000;
    localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
    localparam logic [23:0] RGB_BLACK   = 24'h000000;

    function automatic int total(input timing_t t);
        return t.disp + t.fp + t.pulse + t.bp;
    endfunction

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] rgb;
        case (idx)
            3'd0:    rgb = RGB_WHITE;
            3'd1:    rgb = RGB_YELLOW;
            3'd2:    rgb = RGB_CYAN;
            3'd3:    rgb = RGB_GREEN;
            3'd4:    rgb = RGB_MAGENTA;
            3'd5:    rgb = RGB_RED;
            3'd6:    rgb = RGB_BLUE;
            default: rgb = RGB_BLACK;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal in pixels or vertical in lines): a wrapping
// position counter with active, sync and terminal-count decodes.
module vga_axis_counter #(
    parameter int DISP  = 800,
    parameter int FP    = 40,
    parameter int PULSE = 48,
    parameter int BP    = 40
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  inc,
    output logic [$clog2(DISP+FP+PULSE+BP)-1:0]   cnt,
    output logic                                  active,
    output logic                                  sync,
    output logic                                  wrap
);

    localparam int TOTAL = DISP + FP + PULSE + BP;
    localparam int W     = $clog2(TOTAL);

    logic [W-1:0] cnt_q, cnt_d;

    // wrap is the terminal count itself, so the top can also use it for look-ahead
    always_comb begin
        wrap   = (cnt_q == W'(TOTAL - 1));
        active = (cnt_q < W'(DISP));
        sync   = (cnt_q >= W'(DISP + FP)) && (cnt_q < W'(DISP + FP + PULSE));
        cnt_d  = cnt_q;
        if (inc) begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised video timing generator with pixel-fetch look-ahead.
// Optional colour-bar test pattern on test_rgb when VGA_TEST_PATTERN_EN is defined.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int HDISP     = 800,
    parameter int HFP       = 40,
    parameter int HPULSE    = 48,
    parameter int HBP       = 40,
    parameter int VDISP     = 480,
    parameter int VFP       = 13,
    parameter int VPULSE    = 3,
    parameter int VBP       = 29,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int PREFETCH  = 2
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic                       enable,
    output logic                       video_hs,
    output logic                       video_vs,
    output logic                       video_de,
    output logic [$clog2(HDISP)-1:0]   pix_x,
    output logic [$clog2(VDISP)-1:0]   pix_y,
    output logic                       line_start,
    output logic                       frame_start,
    output logic                       fetch_req,
    output logic [23:0]                test_rgb
);

    localparam timing_t H_TIMING = '{disp: HDISP, fp: HFP, pulse: HPULSE, bp: HBP};
    localparam timing_t V_TIMING = '{disp: VDISP, fp: VFP, pulse: VPULSE, bp: VBP};
    localparam int HTOTAL = total(H_TIMING);
    localparam int VTOTAL = total(V_TIMING);
    localparam int HCW    = $clog2(HTOTAL);
    localparam int VCW    = $clog2(VTOTAL);
    localparam int HSW    = HCW + 1;
    localparam int XW     = $clog2(HDISP);
    localparam int YW     = $clog2(VDISP);

    if (PREFETCH < 0 || PREFETCH > HFP + HPULSE + HBP ||
        HFP == 0 || HPULSE == 0 || HBP == 0 ||
        VFP == 0 || VPULSE == 0 || VBP == 0) begin : g_bad_params
        $error("vga_timing_gen: PREFETCH beyond horizontal blanking or zero porch/pulse");
    end

    logic [HCW-1:0] hcnt;
    logic [VCW-1:0] vcnt;
    logic           h_active, h_sync, h_wrap;
    logic           v_active, v_sync, v_wrap;
    logic           v_inc;

    assign v_inc = enable && h_wrap;

    vga_axis_counter #(
        .DISP(HDISP), .FP(HFP), .PULSE(HPULSE), .BP(HBP)
    ) u_h_counter (
        .clk(pixel_clk), .rst(pixel_rst), .inc(enable),
        .cnt(hcnt), .active(h_active), .sync(h_sync), .wrap(h_wrap)
    );

    vga_axis_counter #(
        .DISP(VDISP), .FP(VFP), .PULSE(VPULSE), .BP(VBP)
    ) u_v_counter (
        .clk(pixel_clk), .rst(pixel_rst), .inc(v_inc),
        .cnt(vcnt), .active(v_active), .sync(v_sync), .wrap(v_wrap)
    );

    // Look-ahead position; PREFETCH never exceeds blanking, so at most one line carry
    logic [HSW-1:0] ahead_sum;
    logic [HCW-1:0] ahead_h;
    logic [VCW-1:0] ahead_v;

    always_comb begin
        ahead_sum = {1'b0, hcnt} + HSW'(PREFETCH);
        ahead_v   = vcnt;
        if (ahead_sum >= HSW'(HTOTAL)) begin
            ahead_sum = ahead_sum - HSW'(HTOTAL);
            ahead_v   = v_wrap ? '0 : vcnt + VCW'(1);
        end
        ahead_h = ahead_sum[HCW-1:0];
    end

    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic          ls_q, ls_d, fs_q, fs_d, fetch_q, fetch_d;
    logic [XW-1:0] pix_x_q, pix_x_d;
    logic [YW-1:0] pix_y_q, pix_y_d;

    always_comb begin
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        ls_d    = ls_q;
        fs_d    = fs_q;
        fetch_d = fetch_q;
        pix_x_d = pix_x_q;
        pix_y_d = pix_y_q;
        if (enable) begin
            de_d    = h_active && v_active;
            hs_d    = h_sync ? HSYNC_POL : ~HSYNC_POL;
            vs_d    = v_sync ? VSYNC_POL : ~VSYNC_POL;
            ls_d    = de_d && (hcnt == '0);
            fs_d    = ls_d && (vcnt == '0);
            fetch_d = (ahead_h < HCW'(HDISP)) && (ahead_v < VCW'(VDISP));
            if (de_d) begin
                pix_x_d = hcnt[XW-1:0];
                pix_y_d = vcnt[YW-1:0];
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hs_q    <= ~HSYNC_POL;
            vs_q    <= ~VSYNC_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            fetch_q <= 1'b0;
            pix_x_q <= '0;
            pix_y_q <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            fetch_q <= fetch_d;
            pix_x_q <= pix_x_d;
            pix_y_q <= pix_y_d;
        end
    end

    assign video_hs    = hs_q;
    assign video_vs    = vs_q;
    assign video_de    = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign fetch_req   = fetch_q;
    assign pix_x       = pix_x_q;
    assign pix_y       = pix_y_q;

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = (HDISP / 8 > 0) ? HDISP / 8 : 1;

    logic [23:0]    rgb_q, rgb_d;
    logic [HCW-1:0] bar;
    logic [2:0]     bar_idx;

    // Any remainder columns past the eighth bar stay black
    always_comb begin
        bar     = hcnt / HCW'(BAR_W);
        bar_idx = (bar > HCW'(7)) ? 3'd7 : bar[2:0];
        rgb_d   = rgb_q;
        if (enable) begin
            rgb_d = de_d ? bar_colour(bar_idx) : 24'h000000;
        end
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            rgb_q <= '0;
        end else begin
            rgb_q <= rgb_d;
        end
    end

    assign test_rgb = rgb_q;
`else
    assign test_rgb = 24'h000000;
`endif

endmodule
